// File: rtl/fp_addsub_seq_if.sv
// Handshake and adder-facing bus of the FP add/sub sequencer.
// The master side issues requests and hosts the combinational fp_adder;
// the slave side is the sequencer itself.
interface fp_addsub_seq_if;
  logic        start;
  logic        op;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] fa_a;
  logic [31:0] fa_b;
  logic [31:0] fa_s;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        invalid;
  logic        overflow;
  logic        zero;

  modport master (
    output start, op, opa, opb, fa_s,
    input  fa_a, fa_b, busy, done, result, invalid, overflow, zero
  );

  modport slave (
    input  start, op, opa, opb, fa_s,
    output fa_a, fa_b, busy, done, result, invalid, overflow, zero
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle sequencer in front of a combinational fp_adder.
// It registers the operands (B sign-flipped for subtract), holds them on the
// adder inputs for SETTLE_CYCLES cycles, then captures the sum.  At capture it
// applies the IEEE-754 special cases and pulses done for one cycle.
module fp_addsub_seq #(
  parameter int SETTLE_CYCLES = 2,  // 1..15
  parameter int CNT_W         = 4   // must hold SETTLE_CYCLES-1
) (
  input  logic           clk,
  input  logic           rst,
  fp_addsub_seq_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPT
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operand classification on the registered adder inputs.
  logic a_nan, a_inf, b_nan, b_inf, signs_differ;
  logic [31:0] cap_result;
  logic        cap_invalid;
  logic        cap_overflow;

  assign a_nan        = (bus.fa_a[30:23] == 8'hFF) && (bus.fa_a[22:0] != 23'h0);
  assign a_inf        = (bus.fa_a[30:23] == 8'hFF) && (bus.fa_a[22:0] == 23'h0);
  assign b_nan        = (bus.fa_b[30:23] == 8'hFF) && (bus.fa_b[22:0] != 23'h0);
  assign b_inf        = (bus.fa_b[30:23] == 8'hFF) && (bus.fa_b[22:0] == 23'h0);
  assign signs_differ = bus.fa_a[31] ^ bus.fa_b[31];

  // Special-case overrides applied to the adder sum, highest priority first.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cap_result   = bus.fa_s;
    cap_invalid  = 1'b0;
    cap_overflow = 1'b0;
    if (a_nan || b_nan) begin
      cap_result  = QNAN;
      cap_invalid = 1'b1;
    end else if (a_inf && b_inf && signs_differ) begin
      cap_result  = QNAN;
      cap_invalid = 1'b1;
    end else if (a_inf) begin
      cap_result = bus.fa_a;
    end else if (b_inf) begin
      cap_result = bus.fa_b;
    end else if (bus.fa_s[30:23] == 8'hFF) begin
      cap_result   = {bus.fa_s[31], 8'hFF, 23'h0};
      cap_overflow = 1'b1;
    end else if ((bus.fa_s[30:0] == 31'h0) && signs_differ) begin
      // Exact cancellation always yields +0 regardless of the adder's sign.
      cap_result = 32'h0000_0000;
    end
  end

  // Sequencer FSM with registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bus.fa_a     <= 32'h0;
      bus.fa_b     <= 32'h0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.result   <= 32'h0;
      bus.invalid  <= 1'b0;
      bus.overflow <= 1'b0;
      bus.zero     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      bus.done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            bus.fa_a <= bus.opa;
            bus.fa_b <= {bus.opb[31] ^ bus.op, bus.opb[30:0]};
            cnt      <= CNT_W'(SETTLE_CYCLES - 1);
            bus.busy <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
          else           state <= S_CAPT;
        end
        S_CAPT: begin
          bus.result   <= cap_result;
          bus.invalid  <= cap_invalid;
          bus.overflow <= cap_overflow;
          bus.zero     <= (cap_result[30:0] == 31'h0);
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          state        <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq with SETTLE_CYCLES=2.
// The fp_adder is a lookup of hand-computed sums for the operand pairs used;
// unknown pairs return a marker so special-case overrides are visible.
module tb_fp_addsub_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  fp_addsub_seq_if bus ();

  fp_addsub_seq #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  function automatic logic [31:0] fa_model(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      {32'h3F80_0000, 32'h4000_0000}: return 32'h4040_0000;  // 1 + 2
      {32'h4040_0000, 32'hBF80_0000}: return 32'h4000_0000;  // 3 - 1
      {32'h3F80_0000, 32'hBF80_0000}: return 32'h8000_0000;  // 1 - 1, wrong-signed zero
      {32'h7F7F_FFFF, 32'h7F7F_FFFF}: return 32'h7F80_0000;  // max + max
      {32'h3F80_0000, 32'h3F80_0000}: return 32'h4000_0000;  // 1 + 1
      {32'h4000_0000, 32'h3F80_0000}: return 32'h4040_0000;  // 2 + 1
      {32'h4040_0000, 32'h3F80_0000}: return 32'h4080_0000;  // 3 + 1
      default:                        return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign bus.fa_s = fa_model(bus.fa_a, bus.fa_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] res,
                           input logic inv, input logic ovf, input logic zer);
    check({tag, "_result"},   bus.result,   res);
    check({tag, "_invalid"},  bus.invalid,  inv);
    check({tag, "_overflow"}, bus.overflow, ovf);
    check({tag, "_zero"},     bus.zero,     zer);
  endtask

  // Issue one op and wait (bounded) for its done pulse.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic o);
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = a;
    bus.opb   = b;
    bus.op    = o;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !bus.done; i++) @(negedge clk);
    check({tag, "_done"}, bus.done, 1'b1);
  endtask

  logic [31:0] opa_seq [13];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.opa   = 32'h0;
    bus.opb   = 32'h0;

    // Reset state
    @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_fa_a", bus.fa_a, 32'h0);
    check("rst_fa_b", bus.fa_b, 32'h0);
    check_out("rst", 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1. Exact latency and busy window for 1 + 2
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = 32'h3F80_0000;
    bus.opb   = 32'h4000_0000;
    bus.op    = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start = 1'b0;
        bus.opa   = 32'h0;  // later operand changes must not matter
      end
      check($sformatf("lat_busy_c%0d", k), bus.busy, (k <= 3));
      check($sformatf("lat_done_c%0d", k), bus.done, (k == 4));
      if (k == 4) check_out("add_1_2", 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    end

    // 2. Subtraction and exact cancellation
    run_op("sub_3_1", 32'h4040_0000, 32'h3F80_0000, 1'b1);
    check("sub_3_1_fa_b", bus.fa_b, 32'hBF80_0000);
    check_out("sub_3_1", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
    run_op("sub_1_1", 32'h3F80_0000, 32'h3F80_0000, 1'b1);
    check_out("sub_1_1", 32'h0000_0000, 1'b0, 1'b0, 1'b1);

    // 3. NaN / Inf handling
    run_op("inf_m_inf", 32'h7F80_0000, 32'h7F80_0000, 1'b1);
    check_out("inf_m_inf", 32'h7FC0_0000, 1'b1, 1'b0, 1'b0);
    run_op("nan_p_1", 32'h7FC0_0001, 32'h3F80_0000, 1'b0);
    check_out("nan_p_1", 32'h7FC0_0000, 1'b1, 1'b0, 1'b0);
    run_op("ninf_p_1", 32'hFF80_0000, 32'h3F80_0000, 1'b0);
    check_out("ninf_p_1", 32'hFF80_0000, 1'b0, 1'b0, 1'b0);

    // 4. Finite overflow
    run_op("max_p_max", 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0);
    check_out("max_p_max", 32'h7F80_0000, 1'b0, 1'b1, 1'b0);

    // 5. start held high with opa changing every cycle; accepts at 0, 4, 8
    foreach (opa_seq[i]) opa_seq[i] = 32'h1234_5678;
    opa_seq[0] = 32'h3F80_0000;
    opa_seq[4] = 32'h4000_0000;
    opa_seq[8] = 32'h4040_0000;
    for (int j = 0; j <= 12; j++) begin
      @(negedge clk);
      if (j > 0) check($sformatf("stream_done_j%0d", j), bus.done, (j % 4 == 0));
      if (j == 4)  check("stream_res0", bus.result, 32'h4000_0000);
      if (j == 8)  check("stream_res1", bus.result, 32'h4040_0000);
      if (j == 12) check("stream_res2", bus.result, 32'h4080_0000);
      bus.start = (j < 12);
      bus.opa   = opa_seq[j];
      bus.opb   = 32'h3F80_0000;
      bus.op    = 1'b0;
    end
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("stream_idle_done_%0d", j), bus.done, 1'b0);
    end

    // 6. Asynchronous reset in the middle of WAIT
    @(negedge clk);
    bus.start = 1'b1;
    bus.opa   = 32'h3F80_0000;
    bus.opb   = 32'h4000_0000;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    check("abort_busy_before", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_fa_a", bus.fa_a, 32'h0);
    check_out("abort", 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check($sformatf("abort_no_done_%0d", j), bus.done, 1'b0);
    end
    run_op("after_rst", 32'h3F80_0000, 32'h4000_0000, 1'b0);
    check_out("after_rst", 32'h4040_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("after_rst_done_low", bus.done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
